word_serializer: RTL and testbench

//  Parallel-to-serial engine for the LED data path. Accepts W-bit words (GRB pixels) over a valid/ready interface into a DEPTH-word FIFO.

---
 rtl/word_serializer_pkg.sv | 19 +
 rtl/word_serializer_fifo.sv | 51 +++++
 rtl/word_serializer.sv | 117 +++++++++++
 tb/tb_word_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the LED word serializer.
// State encodings, default word width and a clog2 helper.
package word_serializer_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int LED_W = 24;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/word_serializer_fifo.sv
// Word FIFO for the serializer input.
// Pointers carry one extra wrap bit to tell full from empty.
module word_fifo
    import word_serializer_pkg::*;
#(
    parameter int W     = LED_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_wr;
    logic         do_rd;

    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    // storage write, no reset needed on data
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp[AW-1:0]] <= wdata;
    end

    // pointer update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial engine feeding the LED bit encoder.
// Optional word counter: define WORD_SERIALIZER_WCNT_EN.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int W         = LED_W,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         en,
    output logic         out,
    output logic         out_valid,
    output logic         done,
    output logic         underrun,
    output logic         idle
`ifdef WORD_SERIALIZER_WCNT_EN
    ,
    input  logic         wcnt_clr,
    output logic [15:0]  word_cnt
`endif
);

    localparam int CW = clog2(W);

    ser_state_t    state;
    ser_state_t    state_nx;
    logic [W-1:0]  sr;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          step;
    logic          last;
    logic          fin;

    assign push = in_valid & ~fifo_full;
    assign step = (state == SER_SHIFT) & en;
    assign last = (bit_cnt == CW'(W - 1));
    assign fin  = step & last;
    assign pop  = ~fifo_empty &
                  ((state == SER_IDLE) | fin);

    word_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (push),
        .wdata (in_data),
        .rd    (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= SER_IDLE;
        else       state <= state_nx;
    end

    // next state: load when data waits, drop out when drained
    always_comb begin
        state_nx = state;
        unique case (state)
            SER_IDLE:  if (!fifo_empty) state_nx = SER_SHIFT;
            SER_SHIFT: if (fin && fifo_empty) state_nx = SER_IDLE;
        endcase
    end

    // outputs straight from registered state
    always_comb begin
        out       = MSB_FIRST ? sr[W-1] : sr[0];
        out_valid = (state == SER_SHIFT);
        idle      = (state == SER_IDLE) & fifo_empty;
        in_ready  = ~fifo_full;
    end

    // shifter, bit counter and event pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr       <= '0;
            bit_cnt  <= '0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done     <= fin;
            underrun <= (state == SER_IDLE) & en;
            if (pop) begin
                sr      <= fifo_head;
                bit_cnt <= '0;
            end else if (step) begin
                sr      <= MSB_FIRST ? {sr[W-2:0], 1'b0}
                                     : {1'b0, sr[W-1:1]};
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            end
        end
    end

`ifdef WORD_SERIALIZER_WCNT_EN
    // completed-word counter, clear wins over increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         word_cnt <= '0;
        else if (wcnt_clr) word_cnt <= '0;
        else if (fin)      word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (MSB- and LSB-first copies).
// Bit scoreboard: bits queued at push, checked as en consumes them.
module tb_word_serializer;

    localparam int W     = 24;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [1:0][W-1:0]   in_data;
    logic [1:0]          in_valid;
    logic [1:0]          in_ready;
    logic [1:0]          en;
    logic [1:0]          out;
    logic [1:0]          out_valid;
    logic [1:0]          done;
    logic [1:0]          underrun;
    logic [1:0]          idle;
`ifdef WORD_SERIALIZER_WCNT_EN
    logic [1:0]          wcnt_clr;
    logic [1:0][15:0]    word_cnt;
`endif

    sb_t q0[$];
    sb_t q1[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    word_serializer #(
        .W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .en        (en[0]),
        .out       (out[0]),
        .out_valid (out_valid[0]),
        .done      (done[0]),
        .underrun  (underrun[0]),
        .idle      (idle[0])
`ifdef WORD_SERIALIZER_WCNT_EN
        ,
        .wcnt_clr  (wcnt_clr[0]),
        .word_cnt  (word_cnt[0])
`endif
    );

    word_serializer #(
        .W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .en        (en[1]),
        .out       (out[1]),
        .out_valid (out_valid[1]),
        .done      (done[1]),
        .underrun  (underrun[1]),
        .idle      (idle[1])
`ifdef WORD_SERIALIZER_WCNT_EN
        ,
        .wcnt_clr  (wcnt_clr[1]),
        .word_cnt  (word_cnt[1])
`endif
    );

    task automatic chk(input string tag, input logic obs,
                       input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input bit d, input logic [W-1:0] w,
                             input bit mf);
        sb_t e;
        chk("in_ready_push", in_ready[d], 1'b1);
        in_data[d]  = w;
        in_valid[d] = 1'b1;
        for (int i = 0; i < W; i++) begin
            e.b    = mf ? w[W-1-i] : w[i];
            e.last = (i == W - 1);
            if (d) q1.push_back(e);
            else   q0.push_back(e);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(input bit d);
        int n;
        n = 0;
        while (!out_valid[d] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", out_valid[d], 1'b1);
    endtask

    task automatic consume(input bit d, input bit gap);
        sb_t e;
        chk("sb_avail", (d ? q1.size() : q0.size()) != 0, 1'b1);
        if ((d ? q1.size() : q0.size()) == 0) return;
        e = d ? q1.pop_front() : q0.pop_front();
        chk("out_valid", out_valid[d], 1'b1);
        chk("out_bit", out[d], e.b);
        en[d] = 1'b1;
        @(negedge clk);
        chk("done", done[d], e.last);
        if (gap) begin
            en[d] = 1'b0;
            @(negedge clk);
            chk("done_gap", done[d], 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_data  = '0;
        in_valid = '0;
        en       = '0;
`ifdef WORD_SERIALIZER_WCNT_EN
        wcnt_clr = '0;
`endif
        repeat (2) @(negedge clk);

        // reset state, en held high must have no effect
        en = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_out", out[d], 1'b0);
            chk("rst_out_valid", out_valid[d], 1'b0);
            chk("rst_done", done[d], 1'b0);
            chk("rst_underrun", underrun[d], 1'b0);
            chk("rst_idle", idle[d], 1'b1);
            chk("rst_in_ready", in_ready[d], 1'b1);
`ifdef WORD_SERIALIZER_WCNT_EN
            chk16("rst_word_cnt", word_cnt[d], 16'd0);
`endif
        end
        en   = 2'b00;
        rstn = 1'b1;
        @(negedge clk);

        // en pulse while empty
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        chk("urun_pulse", underrun[0], 1'b1);
        chk("urun_out", out[0], 1'b0);
        chk("urun_idle", idle[0], 1'b1);
        @(negedge clk);
        chk("urun_clear", underrun[0], 1'b0);
        chk("urun_idle2", idle[0], 1'b1);
        chk("urun_ov", out_valid[0], 1'b0);

        // two words, en held, no gap
        push_word(1'b0, 24'hFF0000, 1'b1);
        push_word(1'b0, 24'h00FF00, 1'b1);
        wait_valid(1'b0);
        for (int i = 0; i < 2 * W; i++) begin
            chk("stream_idle", idle[0], 1'b0);
            consume(1'b0, 1'b0);
        end
        en[0] = 1'b0;
        chk("stream_end_idle", idle[0], 1'b1);
        chk("stream_end_out", out[0], 1'b0);
`ifdef WORD_SERIALIZER_WCNT_EN
        chk16("word_cnt_2", word_cnt[0], 16'd2);
`endif
        @(negedge clk);

        // EEEEEE msb-first, en 2 cycles apart
        push_word(1'b0, 24'hEEEEEE, 1'b1);
        chk("lat_pre", out_valid[0], 1'b0);
        @(negedge clk);
        chk("lat_one", out_valid[0], 1'b1);
        for (int i = 0; i < W; i++) consume(1'b0, 1'b1);
        chk("e_idle", idle[0], 1'b1);
        chk("e_ov", out_valid[0], 1'b0);
        chk("e_out", out[0], 1'b0);

        // lsb-first copy, single set bit
        push_word(1'b1, 24'h000001, 1'b0);
        wait_valid(1'b1);
        for (int i = 0; i < W; i++) consume(1'b1, 1'b0);
        en[1] = 1'b0;
        chk("lsb_idle", idle[1], 1'b1);
        chk("lsb_out", out[1], 1'b0);
        @(negedge clk);

        // fill: DEPTH words in FIFO plus one in shifter
        for (int k = 0; k <= DEPTH; k++)
            push_word(1'b0, W'($urandom), 1'b1);
        chk("full_ready", in_ready[0], 1'b0);
        in_data[0]  = 24'hDEAD00;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("full_ready2", in_ready[0], 1'b0);
        for (int i = 0; i < (DEPTH + 1) * W; i++)
            consume(1'b0, 1'b0);
        en[0] = 1'b0;
        chk("drain_idle", idle[0], 1'b1);
        chk("drain_ready", in_ready[0], 1'b1);
        chk("drain_sb", q0.size() == 0, 1'b1);
        @(negedge clk);

`ifdef WORD_SERIALIZER_WCNT_EN
        wcnt_clr[0] = 1'b1;
        @(negedge clk);
        wcnt_clr[0] = 1'b0;
        chk16("wcnt_clr", word_cnt[0], 16'd0);
`endif

        // async reset after 10 bits of a word
        push_word(1'b0, 24'hA5A5A5, 1'b1);
        push_word(1'b0, 24'h123456, 1'b1);
        wait_valid(1'b0);
        for (int i = 0; i < 10; i++) consume(1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out", out[0], 1'b0);
        chk("arst_ov", out_valid[0], 1'b0);
        chk("arst_idle", idle[0], 1'b1);
        chk("arst_ready", in_ready[0], 1'b1);
        chk("arst_done", done[0], 1'b0);
        q0.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_done", done[0], 1'b0);
            chk("post_idle", idle[0], 1'b1);
            chk("post_ov", out_valid[0], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
